// File: rtl/my_and.sv
// my_and: two-input AND with a clocked observation side-band.
// z is purely combinational; z_q, z_rise and hi_cnt are monitoring registers
// sampled on each rising clk edge, cleared by a synchronous active-high rst.
module my_and #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  output logic             z,
  output logic             z_q,
  output logic             z_rise,
  output logic [CNT_W-1:0] hi_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Previous value of z_q; z_rise must always equal z_q & ~z_prev.
  logic z_prev;

  // Combinational AND, independent of clock and reset.
  assign z = x & y;

  // Side-band registers: registered copy, rising-edge pulse, saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q    <= 1'b0;
      z_prev <= 1'b0;
      z_rise <= 1'b0;
      hi_cnt <= '0;
    end else begin
      z_q    <= z;
      z_prev <= z_q;
      z_rise <= z & ~z_q;
      if (z && (hi_cnt != CNT_MAX)) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end
  end

  // The pulse is produced one stage early from z; it must line up with the
  // 0->1 step seen between z_prev and z_q.
  rise_consistent : assert property (@(posedge clk) disable iff (rst)
    z_rise == (z_q & ~z_prev));

endmodule

// File: tb/tb_my_and.sv
// Bench for my_and: two instances (CNT_W = 8 and CNT_W = 3) share inputs; a
// history-based model is compared every cycle, plus literal expectations.
module tb_my_and;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       x;
  logic       y;
  logic       z8, zq8, zr8;
  logic [7:0] cnt8;
  logic       z3, zq3, zr3;
  logic [2:0] cnt3;

  int n_cmp;
  int n_bad;

  my_and #(.CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .z(z8), .z_q(zq8), .z_rise(zr8), .hi_cnt(cnt8)
  );

  my_and #(.CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .z(z3), .z_q(zq3), .z_rise(zr3), .hi_cnt(cnt3)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember z sampled at every edge since the last reset edge.
  bit m_valid;
  bit m_last_z;
  bit m_rise;
  int m_hits;

  always @(posedge clk) begin
    bit zs;
    zs = x && y;
    if (rst) begin
      m_valid  = 1'b1;
      m_last_z = 1'b0;
      m_rise   = 1'b0;
      m_hits   = 0;
    end else begin
      m_rise   = zs && !m_last_z;
      m_last_z = zs;
      if (zs) m_hits++;
    end
  end

  // Compare both instances against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("z8",      int'(z8),   int'(x && y));
      check("z3",      int'(z3),   int'(x && y));
      check("z_q8",    int'(zq8),  int'(m_last_z));
      check("z_q3",    int'(zq3),  int'(m_last_z));
      check("z_rise8", int'(zr8),  int'(m_rise));
      check("z_rise3", int'(zr3),  int'(m_rise));
      check("hi_cnt8", int'(cnt8), (m_hits > 255) ? 255 : m_hits);
      check("hi_cnt3", int'(cnt3), (m_hits > 7) ? 7 : m_hits);
    end
  end

  // Apply inputs just after a falling edge and hold them for n rising edges.
  task automatic cyc(input bit a, input bit b, input bit r, input int n);
    x = a; y = b; rst = r;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    m_valid = 1'b0;
    clk_en  = 1'b0;
    rst = 1'b1; x = 1'b0; y = 1'b0;

    // Truth table with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      x = i[1]; y = i[0];
      #1;
      check("tt_z8", int'(z8), (i == 3) ? 1 : 0);
      check("tt_z3", int'(z3), (i == 3) ? 1 : 0);
      #9;
    end

    clk_en = 1'b1;
    @(negedge clk);

    // Reset held with z = 1: side-band stays clear, z does not.
    cyc(1, 1, 1, 2);
    check("rst_z_q", int'(zq8), 0);
    check("rst_rise", int'(zr8), 0);
    check("rst_cnt", int'(cnt8), 0);
    check("rst_z", int'(z8), 1);
    cyc(1, 1, 0, 1);
    check("first_z_q", int'(zq8), 1);
    check("first_rise", int'(zr8), 1);
    cyc(1, 1, 0, 1);
    check("rise_drop", int'(zr8), 0);

    // Edge detect: y toggles with x = 1, 3 cycles per value.
    cyc(1, 0, 0, 1);
    check("fall_no_pulse", int'(zr8), 0);
    cyc(1, 0, 0, 2);
    cyc(1, 1, 0, 1);
    check("re_rise", int'(zr8), 1);
    cyc(1, 1, 0, 2);
    check("re_rise_gone", int'(zr8), 0);
    cyc(1, 0, 0, 3);
    cyc(1, 1, 0, 3);

    // Counter: 5 high edges, then 4 low edges.
    cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 5);
    check("cnt_after_hi", int'(cnt8), 5);
    cyc(1, 0, 0, 4);
    check("cnt_hold", int'(cnt8), 5);

    // Saturation on the 3-bit instance.
    cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 12);
    check("sat3", int'(cnt3), 7);
    check("nosat8", int'(cnt8), 12);
    cyc(1, 1, 1, 1);
    check("sat3_cleared", int'(cnt3), 0);

    // Reset mid-operation with hi_cnt = 4 and z = 1.
    cyc(1, 1, 0, 4);
    check("mid_pre_cnt", int'(cnt8), 4);
    cyc(1, 1, 1, 1);
    check("mid_cnt", int'(cnt8), 0);
    check("mid_z_q", int'(zq8), 0);
    check("mid_z", int'(z8), 1);
    cyc(1, 1, 0, 1);
    check("post_z_q", int'(zq8), 1);
    check("post_rise", int'(zr8), 1);
    check("post_cnt", int'(cnt8), 1);

    // Glitch between edges is not captured: x pulses low then returns high.
    x = 1'b0; #1 x = 1'b1; #1 x = 1'b0; #1 x = 1'b1;
    @(negedge clk);
    check("glitch_cnt", int'(cnt8), 2);
    check("glitch_z_q", int'(zq8), 1);
    cyc(0, 1, 0, 2);
    cyc(1, 1, 0, 1);
    check("late_rise", int'(zr8), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
